// File: rtl/serial_tx_pkg.sv
// Shared types and defaults for the serial transmit buffer.
package serial_tx_pkg;

  localparam int DATA_W_DEF      = 16;
  localparam int OUT_W_DEF       = 4;
  localparam int DEPTH_DEF       = 4;
  localparam int DIV_W_DEF       = 8;
  localparam int DIV_DEFAULT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SEND   = 2'd2,
    PARITY = 2'd3
  } tx_state_t;

  function automatic int nchunk(input int data_w, input int out_w);
    return data_w / out_w;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO with head-of-queue read and registered occupancy count.
module tx_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (level_r == LVL_W'(DEPTH));
  assign empty     = (level_r == {LVL_W{1'b0}});
  assign level     = level_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap at DEPTH-1 for non-power-of-two depths.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/serial_tx_buffer.sv
// Buffered word serialiser with programmable transmit clock divider.
// Optional trailing XOR parity chunk when SERIAL_TX_PARITY_EN is defined.
module serial_tx_buffer
  import serial_tx_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int OUT_W       = OUT_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DIV_DEFAULT = DIV_DEFAULT_DEF
) (
  input  logic                         Clk,
  input  logic                         ResetN,
  input  logic                         InValid,
  output logic                         InReady,
  input  logic [DATA_W-1:0]            InData,
  input  logic                         ConfigDiv,
  input  logic [31:0]                  DIn,
  output logic                         Busy,
  output logic [$clog2(DEPTH+1)-1:0]   Level,
  output logic                         DOutValid,
  output logic [OUT_W-1:0]             DataOut,
  output logic                         ClkTx
);

  localparam int NCHUNK = nchunk(DATA_W, OUT_W);
  localparam int CNT_W  = $clog2(NCHUNK + 1);
  localparam int LVL_W  = $clog2(DEPTH + 1);

  tx_state_t         state_r, state_s;
  logic [DATA_W-1:0] head_s;
  logic [DATA_W-1:0] shift_r;
  logic [LVL_W-1:0]  level_s;
  logic              full_s, empty_s, push_s, pop_s;
  logic              active_s, toggle_s, fall_s, last_s, busy_s;
  logic [CNT_W-1:0]  chunk_cnt_r;
  logic [DIV_W-1:0]  div_r, div_lat_r, div_cnt_r;
  logic              clk_tx_r;
  logic              unused_din_s;

  assign unused_din_s = ^DIn[31:DIV_W];

  assign push_s   = InValid & ~full_s;
  assign pop_s    = (state_r == LOAD);
  assign active_s = (state_r == SEND) || (state_r == PARITY);
  assign toggle_s = active_s && (div_cnt_r == div_lat_r - DIV_W'(1));
  assign fall_s   = toggle_s && clk_tx_r;
  assign last_s   = (chunk_cnt_r == CNT_W'(NCHUNK - 1));
  assign busy_s   = ~empty_s | (state_r != IDLE);

  assign InReady   = ~full_s;
  assign Busy      = busy_s;
  assign Level     = level_s;
  assign DOutValid = active_s;
  assign DataOut   = shift_r[DATA_W-1 -: OUT_W];
  assign ClkTx     = clk_tx_r;

  tx_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) u_fifo (
    .clk   (Clk),
    .rst_n (ResetN),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (InData),
    .rdata (head_s),
    .level (level_s),
    .full  (full_s),
    .empty (empty_s)
  );

`ifdef SERIAL_TX_PARITY_EN
  logic [OUT_W-1:0] parity_s, parity_r;

  // XOR of every chunk of the word about to be loaded.
  always_comb begin
    parity_s = {OUT_W{1'b0}};
    for (int i = 0; i < NCHUNK; i++) begin
      parity_s = parity_s ^ head_s[i*OUT_W +: OUT_W];
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; the final chunk (data or parity) decides between reload and idle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!empty_s) state_s = LOAD;
        else          state_s = IDLE;
      end
      LOAD: state_s = SEND;
      SEND: begin
        if (fall_s && last_s) begin
`ifdef SERIAL_TX_PARITY_EN
          state_s = PARITY;
`else
          state_s = empty_s ? IDLE : LOAD;
`endif
        end else begin
          state_s = SEND;
        end
      end
      PARITY: begin
        if (fall_s) state_s = empty_s ? IDLE : LOAD;
        else        state_s = PARITY;
      end
      default: state_s = IDLE;
    endcase
  end

  // Divider configuration; only accepted while the block is fully idle.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      div_r <= DIV_W'(DIV_DEFAULT);
    end else if (ConfigDiv && !busy_s) begin
      div_r <= (DIn[DIV_W-1:0] == {DIV_W{1'b0}}) ? DIV_W'(1) : DIn[DIV_W-1:0];
    end else begin
      div_r <= div_r;
    end
  end

  // Shift register, chunk counter and transmit clock generation.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      shift_r     <= {DATA_W{1'b0}};
      chunk_cnt_r <= {CNT_W{1'b0}};
      div_lat_r   <= DIV_W'(DIV_DEFAULT);
      div_cnt_r   <= {DIV_W{1'b0}};
      clk_tx_r    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_r    <= {OUT_W{1'b0}};
`endif
    end else if (state_r == LOAD) begin
      shift_r     <= head_s;
      chunk_cnt_r <= {CNT_W{1'b0}};
      div_lat_r   <= div_r;
      div_cnt_r   <= {DIV_W{1'b0}};
      clk_tx_r    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_r    <= parity_s;
`endif
    end else if (active_s) begin
      if (toggle_s) begin
        div_cnt_r <= {DIV_W{1'b0}};
        clk_tx_r  <= ~clk_tx_r;
        if (clk_tx_r) begin
          chunk_cnt_r <= chunk_cnt_r + CNT_W'(1);
`ifdef SERIAL_TX_PARITY_EN
          if (state_r == SEND && last_s) shift_r <= {parity_r, {(DATA_W-OUT_W){1'b0}}};
          else                           shift_r <= {shift_r[DATA_W-OUT_W-1:0], {OUT_W{1'b0}}};
`else
          shift_r <= {shift_r[DATA_W-OUT_W-1:0], {OUT_W{1'b0}}};
`endif
        end
      end else begin
        div_cnt_r <= div_cnt_r + DIV_W'(1);
      end
    end else begin
      div_cnt_r <= {DIV_W{1'b0}};
      clk_tx_r  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_tx_buffer.sv
// Scoreboard bench for serial_tx_buffer: expected chunks queued at push, checked as they stream out.
module tb_serial_tx_buffer;

  localparam int DATA_W = 16;
  localparam int OUT_W  = 4;
  localparam int DEPTH  = 4;
  localparam int NCHUNK = DATA_W / OUT_W;

  typedef struct {
    logic [OUT_W-1:0] chunk;
    int               div;
  } exp_t;

  logic              Clk = 1'b0;
  logic              ResetN;
  logic              InValid;
  logic              InReady;
  logic [DATA_W-1:0] InData;
  logic              ConfigDiv;
  logic [31:0]       DIn;
  logic              Busy;
  logic [2:0]        Level;
  logic              DOutValid;
  logic [OUT_W-1:0]  DataOut;
  logic              ClkTx;

  exp_t exp_q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   model_div = 2;
  int   mon_cyc = 0;
  int   gap = 0;
  bit   prev_valid = 1'b0;
  bit   gap_chk = 1'b0;
  bit   have_prev = 1'b0;

  serial_tx_buffer dut (
    .Clk       (Clk),
    .ResetN    (ResetN),
    .InValid   (InValid),
    .InReady   (InReady),
    .InData    (InData),
    .ConfigDiv (ConfigDiv),
    .DIn       (DIn),
    .Busy      (Busy),
    .Level     (Level),
    .DOutValid (DOutValid),
    .DataOut   (DataOut),
    .ClkTx     (ClkTx)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push_word(input logic [DATA_W-1:0] w);
    exp_t e;
    logic [OUT_W-1:0] par;
    par = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      e.chunk = w[DATA_W-1-i*OUT_W -: OUT_W];
      e.div   = model_div;
      par     = par ^ e.chunk;
      exp_q.push_back(e);
    end
`ifdef SERIAL_TX_PARITY_EN
    e.chunk = par;
    e.div   = model_div;
    exp_q.push_back(e);
`endif
  endtask

  // Called just after a falling edge; returns just after the falling edge following the push.
  task automatic push_word(input logic [DATA_W-1:0] w);
    int n;
    InValid = 1'b1;
    InData  = w;
    n = 0;
    while (!InReady && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check_eq("push_accept", {31'd0, InReady}, 32'd1);
    sb_push_word(w);
    @(negedge Clk);
    InValid = 1'b0;
  endtask

  task automatic config_div(input logic [31:0] v, input bit expect_load);
    ConfigDiv = 1'b1;
    DIn       = v;
    @(negedge Clk);
    ConfigDiv = 1'b0;
    DIn       = 32'd0;
    if (expect_load) model_div = (v[7:0] == 8'd0) ? 1 : int'(v[7:0]);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge Clk);
    while (Busy && n < 2000) begin
      @(negedge Clk);
      n++;
    end
    check_eq({tag, "_idle"}, {31'd0, Busy}, 32'd0);
    check_eq({tag, "_sb_drain"}, exp_q.size(), 32'd0);
    check_eq({tag, "_chunk_done"}, mon_cyc, 32'd0);
    check_eq({tag, "_valid_low"}, {31'd0, DOutValid}, 32'd0);
  endtask

  // Output monitor: pops one expected chunk per chunk period and checks data and ClkTx phase.
  always @(negedge Clk) begin
    if (!ResetN) begin
      mon_cyc    = 0;
      gap        = 0;
      prev_valid = 1'b0;
      have_prev  = 1'b0;
    end else begin
      if (DOutValid) begin
        if (!prev_valid && gap_chk && have_prev) check_eq("word_gap", gap, 32'd1);
        have_prev = gap_chk;
        if (mon_cyc == 0) begin
          if (exp_q.size() == 0) check_eq("sb_unexpected_chunk", 32'd0, 32'd1);
          else cur = exp_q.pop_front();
        end
        check_eq("data_out", {28'd0, DataOut}, {28'd0, cur.chunk});
        check_eq("clk_tx", {31'd0, ClkTx}, (mon_cyc >= cur.div) ? 32'd1 : 32'd0);
        mon_cyc++;
        if (mon_cyc == 2 * cur.div) mon_cyc = 0;
        gap = 0;
      end else begin
        if (mon_cyc != 0) check_eq("chunk_len", mon_cyc, 32'd0);
        mon_cyc = 0;
        gap++;
      end
      prev_valid = DOutValid;
    end
  end

  initial begin
    bit found;
    ResetN    = 1'b0;
    InValid   = 1'b0;
    InData    = '0;
    ConfigDiv = 1'b0;
    DIn       = 32'd0;
    repeat (2) @(negedge Clk);
    check_eq("rst_level", {29'd0, Level}, 32'd0);
    check_eq("rst_in_ready", {31'd0, InReady}, 32'd1);
    check_eq("rst_busy", {31'd0, Busy}, 32'd0);
    check_eq("rst_valid", {31'd0, DOutValid}, 32'd0);
    check_eq("rst_data", {28'd0, DataOut}, 32'd0);
    check_eq("rst_clk_tx", {31'd0, ClkTx}, 32'd0);
    ResetN = 1'b1;
    @(negedge Clk);

    // Default divider after reset.
    push_word(16'h3C96);
    wait_idle("div_default");

    // Div=1: latency, 8-cycle burst, Busy drop.
    config_div(32'd1, 1'b1);
    push_word(16'hABCD);
    check_eq("t1_busy_after_push", {31'd0, Busy}, 32'd1);
    check_eq("t1_valid_k1", {31'd0, DOutValid}, 32'd0);
    @(negedge Clk);
    check_eq("t1_valid_load", {31'd0, DOutValid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      check_eq("t1_valid_burst", {31'd0, DOutValid}, 32'd1);
      check_eq("t1_busy_burst", {31'd0, Busy}, 32'd1);
    end
    @(negedge Clk);
    check_eq("t1_valid_end", {31'd0, DOutValid}, 32'd0);
    check_eq("t1_busy_end", {31'd0, Busy}, 32'd0);
    wait_idle("t1");

    // Div=3, then Div=0 stored as 1.
    config_div(32'h0000_0003, 1'b1);
    push_word(16'h1234);
    wait_idle("t2_div3");
    config_div(32'h0000_0000, 1'b1);
    push_word(16'h5678);
    wait_idle("t2_div0");

    // Back-to-back stream filling the FIFO; mid-stream ConfigDiv ignored.
    gap_chk = 1'b1;
    push_word(16'h9ABC);
    push_word(16'hDEF0);
    push_word(16'h1357);
    push_word(16'h2468);
    push_word(16'hACE1);
    check_eq("t3_level_full", {29'd0, Level}, 32'd4);
    check_eq("t3_in_ready_full", {31'd0, InReady}, 32'd0);
    config_div(32'h0000_0007, 1'b0);
    wait_idle("t3_stream");
    gap_chk = 1'b0;
    push_word(16'h4321);
    wait_idle("t3_div_kept");

    // Reset during the second chunk, then a clean word.
    push_word(16'h7E5A);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge Clk);
      #2;
      if (DOutValid && DataOut == 4'hE) found = 1'b1;
    end
    check_eq("t4_reach_chunk2", {31'd0, found}, 32'd1);
    ResetN = 1'b0;
    #1;
    check_eq("t4_rst_valid", {31'd0, DOutValid}, 32'd0);
    check_eq("t4_rst_data", {28'd0, DataOut}, 32'd0);
    check_eq("t4_rst_clk_tx", {31'd0, ClkTx}, 32'd0);
    check_eq("t4_rst_level", {29'd0, Level}, 32'd0);
    check_eq("t4_rst_busy", {31'd0, Busy}, 32'd0);
    exp_q.delete();
    model_div = 2;
    @(negedge Clk);
    #2;
    ResetN = 1'b1;
    push_word(16'h7E5A);
    wait_idle("t4_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_tx_buffer.md
Name: serial_tx_buffer

Overview:
- Parametrised successor to the calculator's serial output stage.
- Accepts result words over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Serialises each word MSB-chunk-first on DataOut, qualified by DOutValid and a generated ClkTx.
- ClkTx comes from a runtime-programmable divider loaded via ConfigDiv/DIn; sits between the ALU/memory datapath and the external transmit pins.

Parameters:
- DATA_W, 16, result word width; must be a multiple of OUT_W.
- OUT_W, 4, DataOut chunk width.
- DEPTH, 4, FIFO entries (>=2).
- DIV_W, 8, divider register width.
- DIV_DEFAULT, 2, divider value after reset (>=1).

Ports:
- Clk  in  1  system clock, rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- InValid  in  1  InData valid.
- InReady  out  1  FIFO can accept a word.
- InData  in  DATA_W  result word.
- ConfigDiv  in  1  load divider from DIn.
- DIn  in  32  config data; [DIV_W-1:0] is used.
- Busy  out  1  FIFO non-empty or FSM not IDLE.
- Level  out  $clog2(DEPTH+1)  FIFO occupancy.
- DOutValid  out  1  DataOut carries a valid chunk.
- DataOut  out  OUT_W  current chunk.
- ClkTx  out  1  transmit clock; receiver samples on its rising edge.

Behaviour:
- Reset (async, ResetN=0): FIFO empty, Level=0, InReady=1, Busy=0, DOutValid=0, DataOut=0, ClkTx=0, FSM=IDLE, divider=DIV_DEFAULT, divider counter=0. Reset mid-transfer aborts immediately; the partial word is lost.
- Push: occurs when InValid&&InReady at a Clk edge. InReady = (Level<DEPTH) from registered state only. When full, a same-cycle pop does not enable a push.
- Divider load: ConfigDiv=1 with Busy=0 loads the divider from DIn[DIV_W-1:0]. A value of 0 is stored as 1. ConfigDiv while Busy=1 is ignored.
- NCHUNK = DATA_W/OUT_W.
- FSM states: IDLE, LOAD, SEND (plus PARITY under the optional feature).
- IDLE -> LOAD when FIFO non-empty.
- LOAD (1 cycle): pop the FIFO head into the shift register; clear the chunk counter and divider counter; ClkTx=0.
- LOAD -> SEND. DOutValid=1 and DataOut=top chunk from the first SEND cycle.
- SEND timing:
  - Divider counter counts 0..Div-1; at Div-1 it wraps and ClkTx toggles.
  - Each chunk is held for 2*Div Clk cycles: ClkTx low for Div cycles, then high for Div cycles.
  - On the high->low toggle the shift register advances by OUT_W and the chunk counter increments.
- After the last chunk's high->low toggle: if the FIFO is non-empty go to LOAD (1-cycle DOutValid=0 gap), else go to IDLE. DOutValid=0 and ClkTx=0 outside SEND/PARITY.
- Latency: a push into an empty, idle block at edge k gives DOutValid=1 after edge k+2.
- The divider value is latched per word at LOAD, so it is stable during a word.
- Busy=1 from the cycle after the push until the return to IDLE.

Optional Feature:
- SERIAL_TX_PARITY_EN defined: after the last data chunk the FSM enters PARITY.
  - PARITY emits one extra chunk equal to the XOR of all NCHUNK chunks, with the same 2*Div timing and DOutValid=1.
  - Exit rules from PARITY are identical to those for the last data chunk.
- Undefined: no PARITY state; a word is exactly NCHUNK chunks.

Decomposition:
- Package serial_tx_pkg:
  - tx_state_t enum (IDLE, LOAD, SEND, PARITY).
  - Function nchunk(DATA_W,OUT_W).
  - Default parameter constants.
- Sub-module tx_fifo: synchronous FIFO parametrised by width/depth; provides Level, Full, Empty, push/pop ports.
- Divider and FSM stay in serial_tx_buffer.

Test Plan:
- Reset, push 0xABCD, Div=1 -> DOutValid high 8 cycles starting 2 cycles after push; DataOut A,B,C,D, each for 2 cycles; ClkTx pattern 0,1 per chunk; Busy drops the cycle after the last chunk.
- ConfigDiv=1 with DIn=0x03 while idle, push 0x1234 -> each chunk held 6 cycles (3 with ClkTx low, 3 high). Repeat with DIn=0 -> behaves as Div=1.
- Push 5 words back-to-back with DEPTH=4 -> InReady=0 once Level=4. All accepted words are sent in order with a 1-cycle DOutValid gap between them. ConfigDiv asserted mid-stream has no effect.
- Assert ResetN=0 during the second chunk -> outputs immediately at reset values, Level=0. The next push transmits cleanly from the top chunk.
- SERIAL_TX_PARITY_EN: push 0x1234, Div=1 -> chunks 1,2,3,4, then parity 4; DOutValid high 10 cycles.
